// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: SRAM-like data bus between the bridge (master) and memory (slave)
interface dmem_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: M-stage load/store to SRAM-like bus bridge with kseg mapping and pipeline stall
module dmem_bridge #(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en_i,
  input  logic [3:0]    mem_wen_i,
  input  logic [1:0]    mem_size_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [31:0]   mem_wdata_i,
  input  logic          pipe_stall_i,
  output logic [31:0]   mem_rdata_o,
  output logic          mem_stall_o,
  dmem_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t      state, stateNext;
  logic [31:0] addrR, wdataR, rdataR;
  logic [1:0]  sizeR;
  logic [3:0]  wenR;
  logic        dataDone;
  logic [31:0] physAddr;
  assign physAddr = (MAP_KSEG && mem_addr_i[31:30] == 2'b10) ? {3'b000, mem_addr_i[28:0]} : mem_addr_i;
  always_comb begin
    stateNext = state;
    dataDone  = 1'b0;
    case (state)
      IDLE: stateNext = mem_en_i ? ADDR : IDLE;
      ADDR: begin
        dataDone  = bus.data_addr_ok && bus.data_data_ok;
        stateNext = dataDone ? DONE : bus.data_addr_ok ? DATA : ADDR;
      end
      DATA: begin
        dataDone  = bus.data_data_ok;
        stateNext = dataDone ? DONE : DATA;
      end
      DONE: stateNext = pipe_stall_i ? DONE : IDLE;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addrR  <= '0;
      wdataR <= '0;
      sizeR  <= '0;
      wenR   <= '0;
      rdataR <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && mem_en_i) begin
        addrR  <= physAddr;
        wdataR <= mem_wdata_i;
        sizeR  <= mem_size_i;
        wenR   <= mem_wen_i;
      end
      if (dataDone && wenR == 4'b0000) rdataR <= bus.data_rdata;
    end
  end
  // stall is gated by reset so it drops immediately, even with mem_en_i high
  assign mem_stall_o    = rst && ((state == IDLE && mem_en_i) || state == ADDR || state == DATA);
  assign mem_rdata_o    = rdataR;
  assign bus.data_req   = state == ADDR;
  assign bus.data_wr    = |wenR;
  assign bus.data_size  = sizeR;
  assign bus.data_addr  = addrR;
  assign bus.data_wdata = wdataR;
endmodule
